// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin grant arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N        = 16;
  localparam int ARB_IDX_W    = 4;
  localparam int ARB_MAX_HOLD = 64;

endpackage

// File: rtl/idx_decoder.sv
// Binary index to one-hot decoder with enable; all-zero output when disabled.
module idx_decoder #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  for (genvar i = 0; i < N; i++) begin : g_dec
    assign onehot[i] = en && (idx == IDX_W'(i));
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: one owner at a time, grant held until release, priority rotates past the owner.
// Optional watchdog revocation of long-held grants is built when GRANT_TIMEOUT_EN is defined.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDX_W    = ARB_IDX_W,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  if ((1 << IDX_W) != N || N < 2 || N > 16 || MAX_HOLD < 2) begin : g_cfg_err
    $error("rr_grant_arbiter: N must equal 2**IDX_W within 2..16 and MAX_HOLD >= 2");
  end

  arb_state_t       state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] idx_n;
  logic             vld_n;
  logic             rel;
  logic             expire;
  logic             to_n;

  // Priority search: rotate so ptr lands on bit 0, take lowest set bit, add ptr back.
  logic [N-1:0]     req_rot;
  logic [IDX_W-1:0] ffs;
  logic [IDX_W-1:0] win_idx;

  always_comb begin
    req_rot = '0;
    for (int i = 0; i < N; i++) begin
      req_rot[i] = req[IDX_W'(i) + ptr];
    end
  end

  always_comb begin
    ffs = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) ffs = IDX_W'(i);
    end
  end

  assign win_idx = ffs + ptr;
  assign rel     = done || !req[gnt_idx];

`ifdef GRANT_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  logic [HOLD_W-1:0] hold_cnt;

  // Counts cycles spent in GRANT; parked at zero while idle so every grant starts fresh.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) hold_cnt <= '0;
    else                      hold_cnt <= hold_cnt + 1'b1;
  end

  assign expire = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = gnt_idx;
    vld_n   = gnt_vld;
    to_n    = 1'b0;
    case (state)
      IDLE: begin
        vld_n = 1'b0;
        if (|req) begin
          idx_n   = win_idx;
          vld_n   = 1'b1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        // A genuine release beats the watchdog in the same cycle.
        if (rel || expire) begin
          vld_n   = 1'b0;
          ptr_n   = gnt_idx + 1'b1;
          to_n    = !rel;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gnt_idx <= idx_n;
      gnt_vld <= vld_n;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) timeout <= 1'b0;
    else     timeout <= to_n;
  end
`else
  assign timeout = 1'b0;
  logic unused_to;
  assign unused_to = to_n;
`endif

  idx_decoder #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_dec (
    .en     (gnt_vld),
    .idx    (gnt_idx),
    .onehot (gnt)
  );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter with a per-cycle reference model and literal spot checks.
module tb_rr_grant_arbiter;

  localparam int N     = 16;
  localparam int IDX_W = 4;
`ifdef GRANT_TIMEOUT_EN
  localparam int MAX_HOLD = 4;
  localparam bit TO_EN    = 1'b1;
`else
  localparam int MAX_HOLD = 64;
  localparam bit TO_EN    = 1'b0;
`endif

  logic             clk  = 1'b0;
  logic             rst  = 1'b1;
  logic             done = 1'b0;
  logic [N-1:0]     req  = '0;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             timeout;

  rr_grant_arbiter #(
    .N        (N),
    .IDX_W    (IDX_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner number, or free; free owner scans upward from the pointer.
  int m_ptr  = 0;
  int m_idx  = 0;
  int m_hold = 0;
  bit m_vld  = 1'b0;
  bit m_to   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ptr = 0; m_idx = 0; m_hold = 0; m_vld = 1'b0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_vld) begin
        if (done || !req[m_idx]) begin
          m_vld = 1'b0;
          m_ptr = (m_idx + 1) % N;
        end else if (TO_EN && m_hold == MAX_HOLD - 1) begin
          m_vld = 1'b0;
          m_to  = 1'b1;
          m_ptr = (m_idx + 1) % N;
        end else begin
          m_hold++;
        end
      end else if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            m_idx = (m_ptr + k) % N;
            break;
          end
        end
        m_vld  = 1'b1;
        m_hold = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic [N-1:0] e_gnt;
      e_gnt = m_vld ? (N'(1) << m_idx) : '0;
      chk("model_gnt", gnt, e_gnt);
      chk("model_idx", gnt_idx, m_idx);
      chk("model_vld", gnt_vld, m_vld);
      chk("model_timeout", timeout, m_to);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi;

    // 1: reset with all requests high
    rst = 1'b1; req = 16'hFFFF;
    step(); armed = 1'b1; step();
    chk("rst_gnt", gnt, 0);
    chk("rst_idx", gnt_idx, 0);
    chk("rst_vld", gnt_vld, 0);
    chk("rst_timeout", timeout, 0);

    // 2: single requester, release, then pointer moved to 1
    rst = 1'b0; req = 16'h0001; step();
    chk("t2_gnt", gnt, 16'h0001);
    chk("t2_idx", gnt_idx, 0);
    done = 1'b1; step();
    chk("t2_release", gnt_vld, 0);
    done = 1'b0; req = 16'h0003; step();
    chk("t2_ptr1_idx", gnt_idx, 1);
    chk("t2_ptr1_gnt", gnt, 16'h0002);
    req = '0; step();
    chk("t2_drop_vld", gnt_vld, 0);

    // 3: full rotation with one IDLE cycle between grants
    rst = 1'b1; req = 16'hFFFF; step();
    rst = 1'b0; step();
    for (int i = 0; i <= N; i++) begin
      chk("t3_vld", gnt_vld, 1);
      chk("t3_idx", gnt_idx, i % N);
      chk("t3_gnt", gnt, 32'(1) << (i % N));
      done = 1'b1; step();
      chk("t3_gap", gnt_vld, 0);
      done = 1'b0; step();
    end

    // 4: wrap from ptr=6 past 15 to index 0
    rst = 1'b1; req = '0; step();
    rst = 1'b0; req = 16'h0020; step();
    chk("t4_owner", gnt_idx, 5);
    req = 16'h0021; done = 1'b1; step();
    chk("t4_release", gnt_vld, 0);
    done = 1'b0; step();
    chk("t4_wrap_gnt", gnt, 16'h0001);
    chk("t4_wrap_idx", gnt_idx, 0);

    // 5: reset mid-grant
    rst = 1'b1; req = '0; step();
    rst = 1'b0; req = 16'h0200; step();
    chk("t5_owner", gnt_idx, 9);
    step();
    rst = 1'b1; step();
    chk("t5_rst_gnt", gnt, 0);
    chk("t5_rst_idx", gnt_idx, 0);
    chk("t5_rst_vld", gnt_vld, 0);
    rst = 1'b0; step();
    chk("t5_regrant_idx", gnt_idx, 9);
    chk("t5_regrant_gnt", gnt, 16'h0200);

    // 6: held request with no done
    rst = 1'b1; req = '0; step();
    rst = 1'b0; req = 16'h0008; step();
    hi = 0;
`ifdef GRANT_TIMEOUT_EN
    for (int c = 0; c < 10 && gnt_vld; c++) begin
      hi++;
      step();
    end
    chk("t6_hold_cycles", hi, 4);
    chk("t6_timeout", timeout, 1);
    chk("t6_revoked_gnt", gnt, 0);
    step();
    chk("t6_timeout_pulse", timeout, 0);
    chk("t6_regrant_idx", gnt_idx, 3);
    chk("t6_regrant_vld", gnt_vld, 1);
`else
    for (int c = 0; c < 100; c++) begin
      if (gnt_vld && gnt == 16'h0008 && !timeout) hi++;
      step();
    end
    chk("t6_hold_cycles", hi, 100);
    chk("t6_still_vld", gnt_vld, 1);
`endif

    req = '0; step();
    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
